wb3_burst_master: RTL and testbench
===================================

Name: wb3_burst_master

Overview:
- Parametrised Wishbone B3 bus master; drives the I2C core's register port from a command/response stream.
- Generalises the fixed 3-bit-address/8-bit-data Wishbone hookup to configurable address and data widths.
- Adds byte selects, incrementing bursts with CTI/BTE, ERR/RTY handling, an optional watchdog, and interrupt edge capture.
- Sits between the testbench/CPU-side sequencer and the slave Wishbone port.

Parameters:
- ADDR_WIDTH, 3: Wishbone address width.
- DATA_WIDTH, 8: Wishbone data width, a multiple of 8. SEL_WIDTH = DATA_WIDTH/8.
- MAX_BURST, 8: maximum beats per command. LEN_WIDTH = clog2(MAX_BURST).
- RETRY_MAX, 3: RTY terminations tolerated per beat before the command aborts.
- TIMEOUT, 255: cycles with stb high and no termination before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats minus 1.
- cmd_sel  in  SEL_WIDTH  byte selects, applied to every beat.
- wdata  in  DATA_WIDTH  write beat data.
- wdata_valid  in  1  write beat offered.
- wdata_ready  out  1  write beat taken.
- rsp_valid  out  1  one-cycle pulse per completed beat, or on abort.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- rsp_last  out  1  final response of the command.
- rsp_err  out  1  beat/command ended by ERR, retry exhaustion or timeout.
- adr  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- we  out  1  Wishbone write enable.
- sel  out  SEL_WIDTH  Wishbone byte selects.
- stb  out  1  Wishbone strobe.
- cyc  out  1  Wishbone cycle.
- cti  out  3  cycle type identifier.
- bte  out  2  burst type extension; constant 2'b00 (linear).
- ack  in  1  slave acknowledge.
- err  in  1  slave error.
- rty  in  1  slave retry.
- inta  in  1  slave interrupt, synchronous to clk.
- irq  out  1  registered copy of inta.
- irq_rise  out  1  one-cycle pulse on an inta 0->1 edge.

Behaviour:
- Reset: all outputs 0, including cmd_ready; FSM goes to IDLE. Reset in mid-transfer drops cyc/stb at once, with no response.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch we, addr, len, sel; clear beat and retry counters. Go to WDAT if write, else BUS.
  - WDAT: cyc=1, stb=0, wdata_ready=1. On wdata_valid, register wdata into dat_o and go to BUS. The first-beat stb is the cycle after wdata acceptance.
  - BUS: cyc=stb=1. Per-cycle termination priority is err > rty > ack.
    - ack: rsp_valid pulses the next cycle with rsp_data=dat_i (reads). adr increments by 1 modulo 2^ADDR_WIDTH; beat count increments; retry count clears.
      - Last beat: go to IDLE with rsp_last=1; cyc/stb drop the cycle after ack.
      - Not last, read: stay in BUS with stb high (back-to-back).
      - Not last, write: go to WDAT.
    - rty: stb drops for one cycle (cyc stays high); retry count increments. If the count exceeds RETRY_MAX, go to ABORT; otherwise re-issue the same beat.
    - err: go to ABORT.
  - ABORT: one cycle with cyc=stb=0, rsp_valid=rsp_last=rsp_err=1; then IDLE. Remaining beats are discarded.
- CTI rules:
  - len=0: 3'b000.
  - Burst, non-last beat: 3'b010.
  - Burst, last beat: 3'b111.
- Handshakes: cmd_ready is 0 outside IDLE. A command and ack never overlap, so a new command is accepted no earlier than the cycle after rsp_last.
- Response latency: read beat rsp_valid = ack cycle + 1.
- irq = inta delayed 1 cycle. irq_rise = inta & ~irq.

Optional Feature:
- Macro: WB3_BURST_MASTER_TIMEOUT_EN.
- Defined: a counter clears on each stb rising edge or termination and counts cycles with stb high. On reaching TIMEOUT, the FSM goes to ABORT (rsp_err=1).
- Undefined: no counter; the master waits indefinitely for termination, and TIMEOUT is ignored.

Test Plan:
- Single read: cmd_addr=3'h2, len=0, slave returns 8'hA5 with ack 2 cycles after stb. Expect:
  - cti=000;
  - one rsp_valid with rsp_data=A5, rsp_last=1, rsp_err=0;
  - cyc low the cycle after ack.
- 4-beat read burst from addr 3'h6, ack every cycle. Expect:
  - adr sequence 6,7,0,1 (wrap);
  - cti 010,010,010,111;
  - stb continuous;
  - 4 rsp pulses, last with rsp_last=1.
- 3-beat write, wdata_valid delayed 3 cycles on beat 2. Expect:
  - cyc held high while stb drops during the wait;
  - dat_o beats match the supplied data;
  - rsp_err=0 on the final response.
- RTY on every attempt, RETRY_MAX=3. Expect 4 stb assertions for the same adr, then an ABORT response with rsp_err=1, rsp_last=1.
- Simultaneous ack and err on beat 1 of a 2-beat read. Expect the err path: single response with rsp_err=1, and beat 2 never issued.
- Timeout (macro defined, TIMEOUT=10), slave silent. Expect stb high 10 cycles, then abort with rsp_err=1.
- Reset mid-burst: arst asserted during stb. Expect cyc/stb/cmd_ready at 0 immediately and no rsp_valid.
- Interrupt capture: inta 0->1. Expect irq_rise high for exactly 1 cycle.

Source files
------------

// File: rtl/wb3_burst_master.sv
// Wishbone B3 burst master: turns a command/response stream into classic/incrementing-burst cycles.
// Optional watchdog abort on a silent slave is enabled by defining WB3_BURST_MASTER_TIMEOUT_EN.
module wb3_burst_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int RETRY_MAX  = 3,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / 8,
  localparam int LEN_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] adr,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  stb,
  output logic                  cyc,
  output logic [2:0]            cti,
  output logic [1:0]            bte,
  input  logic                  ack,
  input  logic                  err,
  input  logic                  rty,
  input  logic                  inta,
  output logic                  irq,
  output logic                  irq_rise
);

  typedef enum logic [2:0] {S_IDLE, S_WDAT, S_BUS, S_RETRY, S_ABORT} state_t;

  localparam int RTY_WIDTH = $clog2(RETRY_MAX + 2);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_beat;
  logic [RTY_WIDTH-1:0] r_retry;

  logic                 w_last;
  logic [LEN_WIDTH-1:0] w_next_beat;
  logic [RTY_WIDTH-1:0] w_retry_next;
  logic                 w_timeout;
  logic                 w_abort;

  function automatic logic [2:0] cti_for(input logic [LEN_WIDTH-1:0] beat,
                                         input logic [LEN_WIDTH-1:0] len);
    if (len == '0)       return CTI_CLASSIC;
    else if (beat == len) return CTI_END;
    else                 return CTI_INCR;
  endfunction

  assign w_last       = (r_beat == r_len);
  assign w_next_beat  = r_beat + 1'b1;
  assign w_retry_next = r_retry + 1'b1;
  assign bte          = 2'b00;

`ifdef WB3_BURST_MASTER_TIMEOUT_EN
  localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
  logic [TMO_WIDTH-1:0] r_tmo;

  // Counts from 0 in the first cycle of each strobe; any termination restarts it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                        r_tmo <= '0;
    else if (!stb || ack || err || rty) r_tmo <= '0;
    else                             r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = stb && (r_tmo == TMO_WIDTH'(TIMEOUT - 1));
`else
  // Without the watchdog a negative TIMEOUT is the only value that could fire; none does.
  assign w_timeout = (TIMEOUT < 0);
`endif

  assign w_abort = err || w_timeout || (rty && (w_retry_next > RTY_WIDTH'(RETRY_MAX)));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_beat      <= '0;
      r_retry     <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      adr         <= '0;
      dat_o       <= '0;
      we          <= 1'b0;
      sel         <= '0;
      stb         <= 1'b0;
      cyc         <= 1'b0;
      cti         <= CTI_CLASSIC;
    end else begin
      // NOTE: response flags default low here so each assignment below is a one-cycle pulse.
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            we        <= cmd_we;
            adr       <= cmd_addr;
            sel       <= cmd_sel;
            r_len     <= cmd_len;
            r_beat    <= '0;
            r_retry   <= '0;
            cti       <= cti_for('0, cmd_len);
            cyc       <= 1'b1;
            if (cmd_we) begin
              wdata_ready <= 1'b1;
              r_state     <= S_WDAT;
            end else begin
              stb     <= 1'b1;
              r_state <= S_BUS;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WDAT: begin
          if (wdata_valid) begin
            dat_o       <= wdata;
            wdata_ready <= 1'b0;
            stb         <= 1'b1;
            r_state     <= S_BUS;
          end
        end
        S_BUS: begin
          if (w_abort) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            cti       <= CTI_CLASSIC;
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            r_state   <= S_ABORT;
          end else if (rty) begin
            r_retry <= w_retry_next;
            stb     <= 1'b0;
            r_state <= S_RETRY;
          end else if (ack) begin
            rsp_valid <= 1'b1;
            rsp_data  <= we ? '0 : dat_i;
            adr       <= adr + 1'b1;
            r_beat    <= w_next_beat;
            r_retry   <= '0;
            if (w_last) begin
              rsp_last <= 1'b1;
              cyc      <= 1'b0;
              stb      <= 1'b0;
              we       <= 1'b0;
              cti      <= CTI_CLASSIC;
              r_state  <= S_IDLE;
            end else begin
              cti <= cti_for(w_next_beat, r_len);
              if (we) begin
                stb         <= 1'b0;
                wdata_ready <= 1'b1;
                r_state     <= S_WDAT;
              end
            end
          end
        end
        S_RETRY: begin
          stb     <= 1'b1;
          r_state <= S_BUS;
        end
        S_ABORT: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) irq <= 1'b0;
    else      irq <= inta;
  end

  assign irq_rise = inta & ~irq;

endmodule

// File: tb/tb_wb3_burst_master.sv
// Directed bench for wb3_burst_master: single read, wrapping read burst, paced write burst,
// retry exhaustion, err-over-ack priority, silent slave (watchdog when enabled), reset, irq edge.
module tb_wb3_burst_master;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [2:0] cmd_addr = '0, cmd_len = '0;
  logic       cmd_sel = 1'b0;
  logic [7:0] wdata = '0;
  logic       wdata_valid = 1'b0, wdata_ready;
  logic       rsp_valid, rsp_last, rsp_err;
  logic [7:0] rsp_data;
  logic [2:0] adr;
  logic [7:0] dat_o, dat_i = '0;
  logic       we, sel, stb, cyc;
  logic [2:0] cti;
  logic [1:0] bte;
  logic       ack = 1'b0, err = 1'b0, rty = 1'b0, inta = 1'b0;
  logic       irq, irq_rise;

  int n_cmp = 0;
  int n_mis = 0;

  wb3_burst_master #(
    .ADDR_WIDTH(3), .DATA_WIDTH(8), .MAX_BURST(8), .RETRY_MAX(3), .TIMEOUT(10)
  ) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_sel(cmd_sel), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .adr(adr), .dat_o(dat_o), .dat_i(dat_i),
    .we(we), .sel(sel), .stb(stb), .cyc(cyc), .cti(cti), .bte(bte),
    .ack(ack), .err(err), .rty(rty), .inta(inta), .irq(irq), .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [2:0] a, input logic [2:0] l);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL cmd_ready_before_issue: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_len = l; cmd_sel = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    tick(); tick();
    outs = {cmd_ready, wdata_ready, rsp_valid, rsp_last, rsp_err, rsp_data, adr, dat_o,
            we, sel, stb, cyc, cti, bte, irq, irq_rise};
    n_cmp++;
    if (outs !== 35'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    arst = 1'b0;
    tick();
    n_cmp++;
    if ({cmd_ready, cyc, stb} !== 3'b100) begin
      n_mis++;
      $display("FAIL idle_after_reset: got %b expected 100", {cmd_ready, cyc, stb});
    end
  endtask

  task automatic test_single_read();
    issue(1'b0, 3'h2, 3'd0);
    n_cmp++;
    if ({cyc, stb, we, adr, cti, cmd_ready} !== {1'b1, 1'b1, 1'b0, 3'h2, 3'b000, 1'b0}) begin
      n_mis++;
      $display("FAIL single_issue: got %b expected 1100100000", {cyc, stb, we, adr, cti, cmd_ready});
    end
    tick();
    tick();
    ack = 1'b1; dat_i = 8'hA5;
    tick();
    ack = 1'b0; dat_i = 8'h00;
    n_cmp++;
    if ({rsp_valid, rsp_last, rsp_err, rsp_data, cyc, stb} !== {3'b110, 8'hA5, 2'b00}) begin
      n_mis++;
      $display("FAIL single_rsp: got %b expected 1101010010100", {rsp_valid, rsp_last, rsp_err, rsp_data, cyc, stb});
    end
    tick();
    n_cmp++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_mis++;
      $display("FAIL single_after: got %b expected 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_burst_read();
    logic [2:0] exp_adr [4];
    logic [2:0] exp_cti [4];
    logic [7:0] exp_d;
    exp_adr = '{3'h6, 3'h7, 3'h0, 3'h1};
    exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
    issue(1'b0, 3'h6, 3'd3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({cyc, stb, adr, cti} !== {2'b11, exp_adr[i], exp_cti[i]}) begin
        n_mis++;
        $display("FAIL burst_beat%0d: got cyc/stb/adr/cti %b expected %b", i,
                 {cyc, stb, adr, cti}, {2'b11, exp_adr[i], exp_cti[i]});
      end
      if (i > 0) begin
        exp_d = 8'h10 + 8'(i - 1);
        n_cmp++;
        if ({rsp_valid, rsp_last, rsp_data} !== {2'b10, exp_d}) begin
          n_mis++;
          $display("FAIL burst_rsp%0d: got %b expected %b", i - 1,
                   {rsp_valid, rsp_last, rsp_data}, {2'b10, exp_d});
        end
      end
      ack = 1'b1; dat_i = 8'h10 + 8'(i);
      tick();
    end
    ack = 1'b0; dat_i = 8'h00;
    n_cmp++;
    if ({rsp_valid, rsp_last, rsp_err, rsp_data, cyc, stb} !== {3'b110, 8'h13, 2'b00}) begin
      n_mis++;
      $display("FAIL burst_last_rsp: got %b expected %b",
               {rsp_valid, rsp_last, rsp_err, rsp_data, cyc, stb}, {3'b110, 8'h13, 2'b00});
    end
    tick();
  endtask

  task automatic test_write_burst();
    logic [7:0] exp_d [3];
    logic [2:0] exp_cti [3];
    logic       exp_last;
    exp_d   = '{8'h11, 8'h22, 8'h33};
    exp_cti = '{3'b010, 3'b010, 3'b111};
    issue(1'b1, 3'h1, 3'd2);
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if ({cyc, stb, wdata_ready} !== 3'b101) begin
        n_mis++;
        $display("FAIL wr_wdat%0d: got cyc/stb/wready %b expected 101", b, {cyc, stb, wdata_ready});
      end
      if (b == 1) begin
        for (int w = 0; w < 3; w++) begin
          tick();
          n_cmp++;
          if ({cyc, stb} !== 2'b10) begin
            n_mis++;
            $display("FAIL wr_wait%0d: got cyc/stb %b expected 10", w, {cyc, stb});
          end
        end
      end
      wdata = exp_d[b]; wdata_valid = 1'b1;
      tick();
      wdata_valid = 1'b0;
      n_cmp++;
      if ({cyc, stb, we, adr, cti, dat_o} !== {3'b111, 3'(b + 1), exp_cti[b], exp_d[b]}) begin
        n_mis++;
        $display("FAIL wr_beat%0d: got %b expected %b", b, {cyc, stb, we, adr, cti, dat_o},
                 {3'b111, 3'(b + 1), exp_cti[b], exp_d[b]});
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp_last = (b == 2);
      n_cmp++;
      if ({rsp_valid, rsp_last, rsp_err, rsp_data} !== {1'b1, exp_last, 1'b0, 8'h00}) begin
        n_mis++;
        $display("FAIL wr_rsp%0d: got %b expected %b", b, {rsp_valid, rsp_last, rsp_err, rsp_data},
                 {1'b1, exp_last, 1'b0, 8'h00});
      end
    end
    n_cmp++;
    if ({cyc, stb} !== 2'b00) begin
      n_mis++;
      $display("FAIL wr_end: got cyc/stb %b expected 00", {cyc, stb});
    end
    tick();
  endtask

  task automatic test_retry();
    issue(1'b0, 3'h5, 3'd0);
    for (int a = 0; a < 4; a++) begin
      n_cmp++;
      if ({cyc, stb, adr, rsp_valid} !== {2'b11, 3'h5, 1'b0}) begin
        n_mis++;
        $display("FAIL rty_attempt%0d: got %b expected 111010", a, {cyc, stb, adr, rsp_valid});
      end
      rty = 1'b1;
      tick();
      rty = 1'b0;
      if (a < 3) begin
        n_cmp++;
        if ({cyc, stb, rsp_valid} !== 3'b100) begin
          n_mis++;
          $display("FAIL rty_gap%0d: got %b expected 100", a, {cyc, stb, rsp_valid});
        end
        tick();
      end
    end
    n_cmp++;
    if ({cyc, stb, rsp_valid, rsp_last, rsp_err} !== 5'b00111) begin
      n_mis++;
      $display("FAIL rty_abort: got %b expected 00111", {cyc, stb, rsp_valid, rsp_last, rsp_err});
    end
    tick();
  endtask

  task automatic test_ack_err();
    issue(1'b0, 3'h0, 3'd1);
    n_cmp++;
    if ({stb, cti} !== 4'b1010) begin
      n_mis++;
      $display("FAIL ackerr_issue: got %b expected 1010", {stb, cti});
    end
    ack = 1'b1; err = 1'b1; dat_i = 8'h5A;
    tick();
    ack = 1'b0; err = 1'b0; dat_i = 8'h00;
    n_cmp++;
    if ({rsp_valid, rsp_last, rsp_err, cyc, stb} !== 5'b11100) begin
      n_mis++;
      $display("FAIL ackerr_rsp: got %b expected 11100", {rsp_valid, rsp_last, rsp_err, cyc, stb});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({rsp_valid, cyc, stb, cmd_ready} !== 4'b0001) begin
        n_mis++;
        $display("FAIL ackerr_after%0d: got %b expected 0001", i, {rsp_valid, cyc, stb, cmd_ready});
      end
    end
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'h3, 3'd0);
`ifdef WB3_BURST_MASTER_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({cyc, stb, rsp_valid} !== 3'b110) begin
        n_mis++;
        $display("FAIL tmo_wait%0d: got %b expected 110", i, {cyc, stb, rsp_valid});
      end
      tick();
    end
    n_cmp++;
    if ({cyc, stb, rsp_valid, rsp_last, rsp_err} !== 5'b00111) begin
      n_mis++;
      $display("FAIL tmo_abort: got %b expected 00111", {cyc, stb, rsp_valid, rsp_last, rsp_err});
    end
    tick();
`else
    repeat (20) tick();
    n_cmp++;
    if ({cyc, stb, rsp_valid} !== 3'b110) begin
      n_mis++;
      $display("FAIL silent_wait: got %b expected 110", {cyc, stb, rsp_valid});
    end
    arst = 1'b1;
    tick();
    arst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid_burst();
    issue(1'b0, 3'h0, 3'd3);
    tick();
    arst = 1'b1;
    #1;
    n_cmp++;
    if ({cyc, stb, cmd_ready, rsp_valid} !== 4'b0000) begin
      n_mis++;
      $display("FAIL midrst_drop: got %b expected 0000", {cyc, stb, cmd_ready, rsp_valid});
    end
    tick();
    arst = 1'b0;
    tick();
    n_cmp++;
    if ({cyc, stb, cmd_ready, rsp_valid} !== 4'b0010) begin
      n_mis++;
      $display("FAIL midrst_recover: got %b expected 0010", {cyc, stb, cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_irq();
    inta = 1'b1;
    #1;
    n_cmp++;
    if ({irq, irq_rise} !== 2'b01) begin
      n_mis++;
      $display("FAIL irq_edge: got irq/irq_rise %b expected 01", {irq, irq_rise});
    end
    tick();
    n_cmp++;
    if ({irq, irq_rise} !== 2'b10) begin
      n_mis++;
      $display("FAIL irq_hold1: got irq/irq_rise %b expected 10", {irq, irq_rise});
    end
    tick();
    n_cmp++;
    if ({irq, irq_rise} !== 2'b10) begin
      n_mis++;
      $display("FAIL irq_hold2: got irq/irq_rise %b expected 10", {irq, irq_rise});
    end
    inta = 1'b0;
    tick();
    n_cmp++;
    if ({irq, irq_rise} !== 2'b00) begin
      n_mis++;
      $display("FAIL irq_fall: got irq/irq_rise %b expected 00", {irq, irq_rise});
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_read();
    test_write_burst();
    test_retry();
    test_ack_err();
    test_timeout();
    test_reset_mid_burst();
    test_irq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
